// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between a requester and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter (open-drain pull-low enables)
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic         clk,
  input  logic         reset_n,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int INH_CYC    = CYC_PER_US * INHIBIT_US;
  localparam int TO_CYC     = CYC_PER_US * TIMEOUT_US;
  localparam int CNT_MAX    = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic             data_oe_q, data_oe_d;
  logic             clk_meta_q, clk_sync_q, clk_sync_dly_q;
  logic             data_meta_q, data_sync_q;
  logic             fall;
  logic             timeout;

  // Synchronizers idle high so a released bus never looks like a falling edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q     <= 1'b1;
      clk_sync_q     <= 1'b1;
      clk_sync_dly_q <= 1'b1;
      data_meta_q    <= 1'b1;
      data_sync_q    <= 1'b1;
    end else begin
      clk_meta_q     <= ps2_clk_in;
      clk_sync_q     <= clk_meta_q;
      clk_sync_dly_q <= clk_sync_q;
      data_meta_q    <= ps2_data_in;
      data_sync_q    <= data_meta_q;
    end
  end

  assign fall    = clk_sync_dly_q & ~clk_sync_q;
  assign timeout = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      data_oe_q <= data_oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    data_oe_d = data_oe_q;
    case (state_q)
      IDLE: begin
        if (tx.tx_start) begin
          state_d   = INHIBIT;
          cnt_d     = '0;
          data_oe_d = 1'b0;
          shreg_d   = {1'b1, ~^tx.tx_data, tx.tx_data};
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = REQ;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        state_d  = SEND;
        cnt_d    = '0;
        bitcnt_d = '0;
      end
      SEND, ACK, WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Timeout wins over a fall in the same cycle and releases data at once
        if (timeout) begin
          state_d   = ERR;
          data_oe_d = 1'b0;
        end else if (state_q == SEND) begin
          if (fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[9:1]};
            bitcnt_d  = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              state_d = ACK;
            end
          end
        end else if (state_q == ACK) begin
          if (fall) begin
            state_d = data_sync_q ? ERR : WAIT_IDLE;
          end
        end else if (clk_sync_q && data_sync_q) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_busy  = (state_q == INHIBIT) || (state_q == REQ) || (state_q == SEND) ||
                       (state_q == ACK) || (state_q == WAIT_IDLE);
  assign tx.tx_done  = (state_q == DONE);
  assign tx.tx_error = (state_q == ERR);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a wired-AND PS/2 device model
module tb_ps2_host_tx;
  localparam int H        = 20;
  localparam int INH      = 10000;
  localparam int TO_CYC_T = 20000;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       extra;
    int         gap;
    logic [9:0] bits;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rst_to_n;
  logic clk_oe, data_oe, dev_clk_low, dev_data_low, clk_line, data_line;
  logic to_clk_oe, to_data_oe, to_clk_line, to_data_line;

  ps2_host_tx_if ifc ();
  ps2_host_tx_if ifc_to ();

  assign clk_line     = ~(clk_oe | dev_clk_low);
  assign data_line    = ~(data_oe | dev_data_low);
  assign to_clk_line  = ~to_clk_oe;
  assign to_data_line = ~to_data_oe;

  ps2_host_tx u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx          (ifc),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  ps2_host_tx #(.TIMEOUT_US(200)) u_to (
    .clk         (clk),
    .reset_n     (rst_to_n),
    .tx          (ifc_to),
    .ps2_clk_in  (to_clk_line),
    .ps2_data_in (to_data_line),
    .ps2_clk_oe  (to_clk_oe),
    .ps2_data_oe (to_data_oe)
  );

  int   tests = 0;
  int   fails = 0;
  logic to_finished = 1'b0;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_check(input string name, input int n);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ifc.tx_busy || clk_oe || data_oe) ok = 1'b0;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic dev_clock(input int i, input logic ack, inout logic [9:0] cap);
    repeat (H) @(posedge clk);
    #1 dev_clk_low = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    if (i <= 10) cap[i-1] = data_line;
    dev_clk_low = 1'b0;
    if (i == 10 && ack) dev_data_low = 1'b1;
    if (i == 11) dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [9:0] cap;
    int         inh, req;
    logic       seen, gd, ge, both, pbusy, plines;
    cap = '0;
    ifc.tx_start = 1'b1;
    ifc.tx_data  = v.data;
    @(posedge clk);
    #1 ifc.tx_start = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_busy_after_start", idx), 32'(ifc.tx_busy), 32'd1);
    inh = 0;
    req = 0;
    for (int c = 0; c < 2 * INH; c++) begin
      if (clk_oe && !data_oe) inh++;
      else if (clk_oe && data_oe) req++;
      else break;
      if (v.extra && inh == 100) begin
        ifc.tx_start = 1'b1;
        ifc.tx_data  = 8'h00;
      end else if (v.extra && inh == 101) begin
        ifc.tx_start = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_inhibit_cycles", idx), 32'(inh), 32'(INH));
    chk($sformatf("v%0d_req_cycles", idx), 32'(req), 32'd1);
    chk($sformatf("v%0d_start_bit", idx), {30'd0, clk_oe, data_oe}, 32'd1);
    seen = 1'b0; gd = 1'b0; ge = 1'b0; both = 1'b0; pbusy = 1'b1; plines = 1'b1;
    fork
      begin
        for (int i = 1; i <= 11; i++) dev_clock(i, v.ack, cap);
      end
      begin
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          if (ifc.tx_done && ifc.tx_error) both = 1'b1;
          if (ifc.tx_done || ifc.tx_error) begin
            seen   = 1'b1;
            gd     = ifc.tx_done;
            ge     = ifc.tx_error;
            pbusy  = ifc.tx_busy;
            plines = clk_oe | data_oe;
          end
        end
      end
    join
    chk($sformatf("v%0d_bits", idx), 32'(cap), 32'(v.bits));
    chk($sformatf("v%0d_pulse_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_done", idx), 32'(gd), 32'(v.exp_done));
    chk($sformatf("v%0d_error", idx), 32'(ge), 32'(v.exp_err));
    chk($sformatf("v%0d_done_and_error", idx), 32'(both), 32'd0);
    chk($sformatf("v%0d_busy_in_pulse", idx), 32'(pbusy), 32'd0);
    chk($sformatf("v%0d_lines_released", idx), 32'(plines), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pulse_one_cycle", idx), {30'd0, ifc.tx_done, ifc.tx_error}, 32'd0);
  endtask

  initial begin
    logic reached;
    vecs[0] = '{data: 8'hED, ack: 1'b1, extra: 1'b0, gap: 5,  bits: 10'b1_1_11101101, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hF4, ack: 1'b1, extra: 1'b1, gap: 5,  bits: 10'b1_0_11110100, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'h3C, ack: 1'b0, extra: 1'b0, gap: 40, bits: 10'b1_1_00111100, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{data: 8'h00, ack: 1'b1, extra: 1'b0, gap: 10, bits: 10'b1_1_00000000, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hFF, ack: 1'b1, extra: 1'b0, gap: 0,  bits: 10'b1_1_11111111, exp_done: 1'b1, exp_err: 1'b0};

    reset_n = 1'b0;
    ifc.tx_start = 1'b0;
    ifc.tx_data  = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_busy", 32'(ifc.tx_busy), 32'd0);
    chk("rst_done", 32'(ifc.tx_done), 32'd0);
    chk("rst_error", 32'(ifc.tx_error), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle_check("idle_after_reset", 20);

    // Abort a frame with reset while the host is pulling data low mid-SEND
    @(posedge clk);
    #1 ifc.tx_start = 1'b1;
    ifc.tx_data = 8'hA5;
    @(posedge clk);
    #1 ifc.tx_start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2 * INH && !reached; c++) begin
      @(negedge clk);
      if (!clk_oe && ifc.tx_busy) reached = 1'b1;
    end
    chk("midframe_reached_send", 32'(reached), 32'd1);
    dev_clock(1, 1'b0, vecs[0].bits);
    repeat (H) @(posedge clk);
    #1 dev_clk_low = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("midframe_data_oe_before_reset", 32'(data_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midframe_rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("midframe_rst_data_oe", 32'(data_oe), 32'd0);
    chk("midframe_rst_busy", 32'(ifc.tx_busy), 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    vecs[0].bits = 10'b1_1_11101101;
    idle_check("idle_after_midframe_reset", 20);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].gap > 0) begin
        idle_check($sformatf("v%0d_idle_before_start", i), vecs[i].gap);
        @(posedge clk);
        #1;
      end
      run_frame(vecs[i], i);
    end

    for (int c = 0; c < 50000 && !to_finished; c++) @(negedge clk);
    chk("timeout_test_finished", 32'(to_finished), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Second instance with a short timeout and a device that never clocks
  initial begin
    logic prev_oe, seen_send, err_seen, done_seen, ebusy, elines;
    int   n;
    rst_to_n = 1'b0;
    ifc_to.tx_start = 1'b0;
    ifc_to.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_to_n = 1'b1;
    @(posedge clk);
    #1 ifc_to.tx_start = 1'b1;
    ifc_to.tx_data = 8'h5A;
    @(posedge clk);
    #1 ifc_to.tx_start = 1'b0;
    prev_oe   = 1'b0;
    seen_send = 1'b0;
    for (int c = 0; c < 2 * INH && !seen_send; c++) begin
      @(negedge clk);
      if (prev_oe && !to_clk_oe) seen_send = 1'b1;
      prev_oe = to_clk_oe;
    end
    chk("to_send_entered", 32'(seen_send), 32'd1);
    n = 0; err_seen = 1'b0; done_seen = 1'b0; ebusy = 1'b1; elines = 1'b1;
    for (int c = 0; c < TO_CYC_T + 100 && !err_seen; c++) begin
      @(negedge clk);
      n++;
      if (ifc_to.tx_done) done_seen = 1'b1;
      if (ifc_to.tx_error) begin
        err_seen = 1'b1;
        ebusy    = ifc_to.tx_busy;
        elines   = to_clk_oe | to_data_oe;
      end
    end
    chk("to_error_seen", 32'(err_seen), 32'd1);
    chk("to_error_latency", 32'(n), 32'(TO_CYC_T));
    chk("to_no_done", 32'(done_seen), 32'd0);
    chk("to_busy_in_pulse", 32'(ebusy), 32'd0);
    chk("to_lines_released", 32'(elines), 32'd0);
    to_finished = 1'b1;
  end
endmodule
